// File: rtl/ctrl_word_tracer_if.sv
// Debug read port of the control-word tracer: FIFO head, handshake and occupancy.
interface ctrl_word_tracer_if #(
  parameter int W     = 39,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W+7:0]  rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [LW-1:0] level;

  // Tracer side drives the head entry and occupancy; the host drives ready.
  modport master (output rd_data, output rd_valid, output level, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input level, output rd_ready);
endinterface

// File: rtl/ctrl_word_tracer.sv
// Observation stage for the bcomp control word: logs each change of the word with
// the cycle distance to the previous change in a small FIFO, and folds every
// sampled word into a 16-bit MISR signature.
module ctrl_word_tracer #(
  parameter int          W        = 39,
  parameter int          DEPTH    = 8,
  parameter logic [15:0] SIG_SEED = 16'hFFFF,
  parameter logic [15:0] POLY     = 16'h1021
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [W-1:0]       cw_in,
  ctrl_word_tracer_if.master rd,
  output logic               overflow,
  output logic [15:0]        sig
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // One MISR step: shift with polynomial feedback, then XOR in the word folded to 16 bits.
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [W-1:0] w);
    logic [47:0] f;
    logic [15:0] fold;
    f    = 48'(w);
    fold = f[15:0] ^ f[31:16] ^ f[47:32];
    return ({s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0)) ^ fold;
  endfunction

  // Saturating increment of the 8-bit delta counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [W+7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          have_last;
  logic [W-1:0]  last_word;
  logic [7:0]    cnt;

  logic sample;
  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // clear wins over both the sample and a host pop in the same cycle.
  assign sample  = en && !clear;
  assign capture = sample && (!have_last || (cw_in != last_word));
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = (level_q != '0) && rd.rd_ready && !clear;
  // A full FIFO still accepts the push when the host frees the head slot this cycle.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign rd.rd_valid = (level_q != '0);
  assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
  assign rd.level    = level_q;

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Change-detection history and cycles-since-last-change counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_last <= 1'b0;
      last_word <= '0;
      cnt       <= 8'd0;
    end else if (clear) begin
      have_last <= 1'b0;
      cnt       <= 8'd0;
    end else if (sample) begin
      have_last <= 1'b1;
      last_word <= cw_in;
      cnt       <= capture ? 8'd1 : sat_inc(cnt);
    end
  end

  // Signature accumulates every enabled sample, captured or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SIG_SEED;
    end else if (clear) begin
      sig <= SIG_SEED;
    end else if (sample) begin
      sig <= misr_next(sig, cw_in);
    end
  end

  // Entry storage; contents need no reset since an empty FIFO reads as zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cnt, cw_in};
  end
endmodule

// File: tb/tb_ctrl_word_tracer.sv
module tb_ctrl_word_tracer;
  localparam int          W     = 39;
  localparam int          DEPTH = 8;
  localparam logic [15:0] SEED  = 16'hFFFF;
  localparam logic [15:0] POLY  = 16'h1021;
  localparam logic [W-1:0] A = 39'h3_0000_0006;
  localparam logic [W-1:0] B = 39'h20_0000_2007;
  localparam logic [W-1:0] C = 39'h00_1234_5678;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] cw_in = '0;
  logic         overflow;
  logic [15:0]  sig;

  ctrl_word_tracer_if #(.W(W), .DEPTH(DEPTH)) bus ();

  ctrl_word_tracer #(.W(W), .DEPTH(DEPTH), .SIG_SEED(SEED), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .cw_in(cw_in),
    .rd(bus), .overflow(overflow), .sig(sig)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO as a queue, counters as plain integers.
  logic [W+7:0] q[$];
  int           m_cnt;
  bit           m_have;
  logic [W-1:0] m_last;
  bit           m_ovf;
  logic [15:0]  m_sig;

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [W-1:0] w);
    int     nxt;
    int     fold;
    longint f;
    f    = longint'(w);
    fold = 0;
    for (int k = 0; k < 3; k++) fold = fold ^ int'((f >> (16 * k)) & 64'hFFFF);
    nxt = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) nxt = nxt ^ int'(POLY);
    return 16'(nxt ^ fold);
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_have = 0; m_last = '0; m_ovf = 0; m_sig = SEED;
  endtask

  task automatic model_step(input bit e, input bit c, input bit r, input logic [W-1:0] w);
    bit do_pop;
    if (c) begin
      q.delete();
      m_cnt = 0; m_have = 0; m_ovf = 0; m_sig = SEED;
    end else begin
      do_pop = (q.size() > 0) && r;
      if (do_pop) void'(q.pop_front());
      if (e) begin
        if (!m_have || w != m_last) begin
          if (q.size() < DEPTH) q.push_back({8'(m_cnt), w});
          else m_ovf = 1;
          m_cnt = 1;
        end else begin
          m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end
        m_sig  = ref_misr(m_sig, w);
        m_have = 1;
        m_last = w;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 64'(bus.rd_valid), 64'(q.size() != 0));
    check({tag, ".level"}, 64'(bus.level), 64'(q.size()));
    check({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    check({tag, ".sig"},   64'(sig), 64'(m_sig));
    if (q.size() != 0) check({tag, ".data"}, 64'(bus.rd_data), 64'(q[0]));
  endtask

  // Called #1 after an edge; applies an asynchronous reset pulse well before the next edge.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; bus.rd_ready = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic apply(input bit e, input bit c, input bit r, input logic [W-1:0] w);
    en = e; clear = c; bus.rd_ready = r; cw_in = w;
    model_step(e, c, r, w);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit           rst_first;
    bit           en;
    bit           clr;
    bit           rdy;
    logic [W-1:0] cw;
    bit           ev;
    int           el;
    logic [W+7:0] ed;
    bit           cs;
    logic [15:0]  es;
  } vec_t;

  vec_t tbl[11];
  logic [W-1:0] wv[10];

  initial begin
    bus.rd_ready = 1'b0;
    // rst, en, clr, rdy, cw, exp valid, exp level, exp head, check sig, exp sig
    tbl[0]  = '{1, 1, 0, 0, '0, 1, 1, {8'd0, 39'h0}, 1, 16'hEFDF};
    tbl[1]  = '{1, 1, 0, 0, A,  1, 1, {8'd0, A},     0, 16'h0};
    tbl[2]  = '{0, 1, 0, 0, A,  1, 1, {8'd0, A},     0, 16'h0};
    tbl[3]  = '{0, 1, 0, 0, A,  1, 1, {8'd0, A},     0, 16'h0};
    tbl[4]  = '{0, 1, 0, 0, B,  1, 2, {8'd0, A},     0, 16'h0};
    tbl[5]  = '{0, 1, 0, 0, C,  1, 3, {8'd0, A},     0, 16'h0};
    tbl[6]  = '{0, 0, 0, 1, C,  1, 2, {8'd3, B},     0, 16'h0};
    tbl[7]  = '{0, 0, 0, 1, C,  1, 1, {8'd1, C},     0, 16'h0};
    tbl[8]  = '{0, 0, 0, 1, C,  0, 0, '0,            0, 16'h0};
    tbl[9]  = '{0, 1, 0, 0, C,  0, 0, '0,            0, 16'h0};
    tbl[10] = '{0, 1, 0, 0, A,  1, 1, {8'd2, A},     0, 16'h0};

    @(posedge clk); #1;
    do_reset();
    check("rst.valid", 64'(bus.rd_valid), 64'd0);
    check("rst.level", 64'(bus.level), 64'd0);
    check("rst.data",  64'(bus.rd_data), 64'd0);
    check("rst.ovf",   64'(overflow), 64'd0);
    check("rst.sig",   64'(sig), 64'(SEED));

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_first) do_reset();
      apply(tbl[i].en, tbl[i].clr, tbl[i].rdy, tbl[i].cw);
      check($sformatf("tbl%0d.valid", i), 64'(bus.rd_valid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d.level", i), 64'(bus.level), 64'(tbl[i].el));
      if (tbl[i].ev) check($sformatf("tbl%0d.data", i), 64'(bus.rd_data), 64'(tbl[i].ed));
      if (tbl[i].cs) check($sformatf("tbl%0d.sig", i), 64'(sig), 64'(tbl[i].es));
      else           check($sformatf("tbl%0d.sig", i), 64'(sig), 64'(m_sig));
    end

    // Overflow: nine distinct words with no reads, then a push while popping a full FIFO
    do_reset();
    for (int i = 0; i < 10; i++) wv[i] = W'(64'd1000 + 64'(i) * 64'd7);
    for (int i = 0; i < 9; i++) apply(1, 0, 0, wv[i]);
    check("ovf.level", 64'(bus.level), 64'd8);
    check("ovf.flag",  64'(overflow), 64'd1);
    check("ovf.head",  64'(bus.rd_data), 64'({8'd0, wv[0]}));
    check_model("ovf");
    apply(1, 0, 1, wv[9]);
    check("fullpop.level", 64'(bus.level), 64'd8);
    check("fullpop.head",  64'(bus.rd_data), 64'({8'd1, wv[1]}));
    check_model("fullpop");

    // clear beats a simultaneous new word, then the next capture restarts at delta 0
    apply(1, 1, 1, C);
    check("clr.level", 64'(bus.level), 64'd0);
    check("clr.valid", 64'(bus.rd_valid), 64'd0);
    check("clr.sig",   64'(sig), 64'(SEED));
    check("clr.ovf",   64'(overflow), 64'd0);
    apply(1, 0, 0, B);
    check("clr.next",  64'(bus.rd_data), 64'({8'd0, B}));
    check_model("clr");

    // Delta saturation over a long run of an unchanged word
    do_reset();
    for (int i = 0; i < 300; i++) apply(1, 0, 0, A);
    apply(1, 0, 0, B);
    check("sat.level", 64'(bus.level), 64'd2);
    apply(0, 0, 1, B);
    check("sat.head",  64'(bus.rd_data), 64'({8'd255, B}));
    check_model("sat");

    // en low: nothing captured and the signature holds
    do_reset();
    for (int i = 0; i < 20; i++) apply(0, 0, 0, W'({$urandom, $urandom}));
    check("en0.level", 64'(bus.level), 64'd0);
    check("en0.sig",   64'(sig), 64'(SEED));

    // Asynchronous reset between edges while five entries are queued
    for (int i = 0; i < 5; i++) apply(1, 0, 0, wv[i]);
    check("arst.pre", 64'(bus.level), 64'd5);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", 64'(bus.rd_valid), 64'd0);
    check("arst.level", 64'(bus.level), 64'd0);
    check("arst.sig",   64'(sig), 64'(SEED));
    check("arst.ovf",   64'(overflow), 64'd0);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_model("arst.post");

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] w;
      int sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       w = A;
        1:       w = B;
        2:       w = C;
        3:       w = m_last;
        default: w = W'({$urandom, $urandom});
      endcase
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 60 : 15), w);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
